// File: rtl/tcb_pkg.sv
// Types shared by the TCB arbiter: grant ID and one response-pipeline entry.
package tcb_pkg;

    typedef logic [2:0] tcb_arb_id_t;

    typedef struct packed {
        logic        vld;
        tcb_arb_id_t id;
    } tcb_arb_rsp_t;

    // Next manager in rotation, wrapping at mpn-1.
    function automatic tcb_arb_id_t tcb_arb_next(tcb_arb_id_t id, int mpn);
        return (int'(id) == mpn - 1) ? '0 : id + 3'd1;
    endfunction

endpackage

// File: rtl/tcb_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, modulo MPN.
module tcb_arbiter_rr
    import tcb_pkg::*;
#(
    parameter int MPN = 2
)(
    input  logic [MPN-1:0] req,
    input  tcb_arb_id_t    ptr,
    output logic [MPN-1:0] gnt,
    output tcb_arb_id_t    gnt_id
);

    logic found;

    // With no requester the ID falls back to ptr and gnt stays all-zero.
    always_comb begin
        found  = 1'b0;
        gnt_id = ptr;
        gnt    = '0;
        for (int k = 0; k < MPN; k++) begin
            for (int j = 0; j < MPN; j++) begin
                if (!found && req[j] && (j == (int'(ptr) + k) % MPN)) begin
                    found  = 1'b1;
                    gnt_id = tcb_arb_id_t'(j);
                end
            end
        end
        for (int j = 0; j < MPN; j++)
            gnt[j] = found && (gnt_id == tcb_arb_id_t'(j));
    end

endmodule

// File: rtl/tcb_arbiter.sv
// Shares one TCB subordinate between MPN managers: round-robin grant, request mux,
// fixed-latency response demux. Define TCB_ARBITER_LOCK_EN to add m_lck bus locking.
module tcb_arbiter
    import tcb_pkg::*;
#(
    parameter int MPN = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int DLY = 1
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MPN-1:0]            m_vld,
    input  logic [MPN-1:0]            m_wen,
    input  logic [MPN-1:0][AW-1:0]    m_adr,
    input  logic [MPN-1:0][1:0]       m_siz,
    input  logic [MPN-1:0][DW/8-1:0]  m_ben,
    input  logic [MPN-1:0][DW-1:0]    m_wdt,
`ifdef TCB_ARBITER_LOCK_EN
    input  logic [MPN-1:0]            m_lck,
`endif
    output logic [MPN-1:0]            m_rdy,
    output logic [DW-1:0]             m_rdt,
    output logic [MPN-1:0]            m_err,
    output logic                      s_vld,
    output logic                      s_wen,
    output logic [AW-1:0]             s_adr,
    output logic [1:0]                s_siz,
    output logic [DW/8-1:0]           s_ben,
    output logic [DW-1:0]             s_wdt,
    input  logic                      s_rdy,
    input  logic [DW-1:0]             s_rdt,
    input  logic                      s_err
);

    tcb_arb_id_t    ptr, hold_id, rr_id, gnt_id;
    logic           hold, lock, g_vld, trn_lck, s_trn;
    logic [MPN-1:0] rr_gnt;
    tcb_arb_rsp_t   rsp_out;

    tcb_arbiter_rr #(.MPN(MPN)) u_rr (
        .req    (m_vld),
        .ptr    (ptr),
        .gnt    (rr_gnt),
        .gnt_id (rr_id)
    );

    // A locked bus keeps the grant on ptr, which was left pointing at the owner.
    assign gnt_id = hold ? hold_id : (lock ? ptr : rr_id);
    assign s_vld  = rst & (lock ? g_vld : |rr_gnt);
    assign s_trn  = s_vld & s_rdy;

    always_comb begin
        s_wen = 1'b0;
        s_adr = '0;
        s_siz = '0;
        s_ben = '0;
        s_wdt = '0;
        g_vld = 1'b0;
        m_rdy = '0;
        for (int i = 0; i < MPN; i++) begin
            if (gnt_id == tcb_arb_id_t'(i)) begin
                s_wen    = m_wen[i];
                s_adr    = m_adr[i];
                s_siz    = m_siz[i];
                s_ben    = m_ben[i];
                s_wdt    = m_wdt[i];
                g_vld    = m_vld[i];
                m_rdy[i] = s_rdy & rst;
            end
        end
    end

`ifdef TCB_ARBITER_LOCK_EN
    always_comb begin
        trn_lck = 1'b0;
        for (int i = 0; i < MPN; i++)
            if (gnt_id == tcb_arb_id_t'(i)) trn_lck = m_lck[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       lock <= 1'b0;
        else if (s_trn) lock <= trn_lck;
    end
`else
    assign trn_lck = 1'b0;
    assign lock    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= '0;
            hold    <= 1'b0;
            hold_id <= '0;
        end else if (s_trn) begin
            hold <= 1'b0;
            ptr  <= trn_lck ? gnt_id : tcb_arb_next(gnt_id, MPN);
        end else if (s_vld) begin
            hold    <= 1'b1;
            hold_id <= gnt_id;
        end
    end

    generate
        if (DLY == 0) begin : g_rsp_comb
            assign rsp_out = {s_trn, gnt_id};
        end else begin : g_rsp_pipe
            tcb_arb_rsp_t pipe [DLY];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DLY; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= {s_trn, gnt_id};
                    for (int i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign rsp_out = pipe[DLY-1];
        end
    endgenerate

    assign m_rdt = s_rdt;

    always_comb begin
        m_err = '0;
        for (int i = 0; i < MPN; i++)
            m_err[i] = s_err & rsp_out.vld & (rsp_out.id == tcb_arb_id_t'(i));
    end

`ifndef SYNTHESIS
    a_req_stable: assert property (@(posedge clk) disable iff (!rst)
        (s_vld && !s_rdy) |=> (s_vld && $stable({s_wen, s_adr, s_siz, s_ben, s_wdt})));
    a_hold_vld: assert property (@(posedge clk) disable iff (!rst) hold |-> g_vld);
    a_err_onehot: assert property (@(posedge clk) $onehot0(m_err));
`endif

endmodule
